// File: rtl/stdp_update_scheduler.sv
// STDP update scheduler: per-synapse spike timers, LTP/LTD request queue and one shared weight-update datapath.
// Build option: define STDP_SCHED_RR_EN for a round-robin arbiter; otherwise the lowest pending index wins.
module stdp_update_scheduler #(
  parameter int N_SYN    = 4,
  parameter int W_WIDTH  = 8,
  parameter int T_WIDTH  = 8,
  parameter int T_WINDOW = 16,
  parameter int W_INIT   = 16,
  localparam int IDX_W   = $clog2(N_SYN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_SYN-1:0]   pre_spike,
  input  logic               post_spike,
  input  logic [IDX_W-1:0]   wt_rd_idx,
  output logic [W_WIDTH-1:0] wt_rd_data,
  output logic               busy,
  output logic               upd_valid,
  output logic [IDX_W-1:0]   upd_idx,
  output logic               upd_ltp,
  output logic [T_WIDTH-1:0] upd_dt
);

  localparam logic [T_WIDTH-1:0] T_MAX = '1;
  localparam logic [T_WIDTH-1:0] T_WIN = T_WIDTH'(T_WINDOW);
  localparam logic [W_WIDTH-1:0] W_MAX = '1;
  localparam logic [W_WIDTH-1:0] W_RST = W_WIDTH'(W_INIT);
  localparam logic [IDX_W-1:0]   I_LAST = IDX_W'(N_SYN - 1);

  typedef enum logic {
    IDLE,
    APPLY
  } state_t;

  state_t state;

  logic [W_WIDTH-1:0] weight [N_SYN];
  logic [T_WIDTH-1:0] pre_timer [N_SYN];
  logic [T_WIDTH-1:0] post_timer;

  logic [N_SYN-1:0]   ltp_pend;
  logic [N_SYN-1:0]   ltd_pend;
  logic [T_WIDTH-1:0] ltp_dt [N_SYN];
  logic [T_WIDTH-1:0] ltd_dt [N_SYN];

  logic [N_SYN-1:0]   ltp_set;
  logic [N_SYN-1:0]   ltd_set;
  logic [T_WIDTH-1:0] ltp_new_dt [N_SYN];

  logic [N_SYN-1:0]   pend;
  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;

  logic [IDX_W-1:0]   sel_idx;
  logic               sel_ltp;
  logic [T_WIDTH-1:0] sel_dt;
  logic [W_WIDTH-1:0] sel_w;

  logic [T_WIDTH-1:0] delta_t;
  logic [W_WIDTH-1:0] delta;
  logic [W_WIDTH:0]   sum;
  logic [W_WIDTH-1:0] new_w;

`ifdef STDP_SCHED_RR_EN
  logic [IDX_W-1:0]   rr_ptr;
  logic               found;
  int                 rr_j;
`endif

  assign wt_rd_data = weight[wt_rd_idx];
  assign busy = (|ltp_pend) | (|ltd_pend) | (state != IDLE);

  // Request detection from pre-update timer values; coincident spikes give LTP at dt=0 only
  always_comb begin
    ltp_set = '0;
    ltd_set = '0;
    for (int i = 0; i < N_SYN; i++) begin
      ltp_new_dt[i] = pre_spike[i] ? '0 : pre_timer[i];
      ltp_set[i] = en & post_spike &
                   (pre_spike[i] | (pre_timer[i] < T_WIN));
      ltd_set[i] = en & pre_spike[i] & ~post_spike &
                   (post_timer < T_WIN);
    end
  end

  // Arbiter: choose which synapse the datapath serves next
  always_comb begin
    pend    = ltp_pend | ltd_pend;
    gnt_vld = |pend;
    gnt_idx = '0;
`ifdef STDP_SCHED_RR_EN
    found = 1'b0;
    rr_j  = 0;
    for (int k = 0; k < N_SYN; k++) begin
      rr_j = (int'(rr_ptr) + k) % N_SYN;
      if (!found && pend[rr_j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(rr_j);
      end
    end
`else
    for (int k = N_SYN - 1; k >= 0; k--) begin
      if (pend[k]) gnt_idx = IDX_W'(k);
    end
`endif
  end

  // Saturating weight arithmetic for the latched request
  always_comb begin
    delta_t = T_WIN - sel_dt;
    delta   = W_WIDTH'(delta_t);
    sum     = {1'b0, sel_w} + {1'b0, delta};
    new_w   = sel_w;
    if (sel_ltp) begin
      new_w = sum[W_WIDTH] ? W_MAX : sum[W_WIDTH-1:0];
    end else begin
      new_w = (sel_w < delta) ? '0 : (sel_w - delta);
    end
  end

  // Spike timers: cleared by a spike, otherwise count up and hold at max
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      post_timer <= T_MAX;
      for (int i = 0; i < N_SYN; i++) pre_timer[i] <= T_MAX;
    end else begin
      if (post_spike)
        post_timer <= '0;
      else if (post_timer != T_MAX)
        post_timer <= post_timer + 1'b1;
      for (int i = 0; i < N_SYN; i++) begin
        if (pre_spike[i])
          pre_timer[i] <= '0;
        else if (pre_timer[i] != T_MAX)
          pre_timer[i] <= pre_timer[i] + 1'b1;
      end
    end
  end

  // Update FSM with request queue and weight file; new captures override same-cycle clears
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ltp_pend  <= '0;
      ltd_pend  <= '0;
      sel_idx   <= '0;
      sel_ltp   <= 1'b0;
      sel_dt    <= '0;
      sel_w     <= '0;
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_ltp   <= 1'b0;
      upd_dt    <= '0;
`ifdef STDP_SCHED_RR_EN
      rr_ptr    <= '0;
`endif
      for (int i = 0; i < N_SYN; i++) begin
        weight[i] <= W_RST;
        ltp_dt[i] <= '0;
        ltd_dt[i] <= '0;
      end
    end else begin
      upd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            sel_idx <= gnt_idx;
            sel_w   <= weight[gnt_idx];
            if (ltp_pend[gnt_idx]) begin
              sel_ltp <= 1'b1;
              sel_dt  <= ltp_dt[gnt_idx];
              ltp_pend[gnt_idx] <= 1'b0;
            end else begin
              sel_ltp <= 1'b0;
              sel_dt  <= ltd_dt[gnt_idx];
              ltd_pend[gnt_idx] <= 1'b0;
            end
`ifdef STDP_SCHED_RR_EN
            rr_ptr <= (gnt_idx == I_LAST) ? '0 : gnt_idx + 1'b1;
`endif
            state <= APPLY;
          end
        end
        APPLY: begin
          weight[sel_idx] <= new_w;
          upd_valid <= 1'b1;
          upd_idx   <= sel_idx;
          upd_ltp   <= sel_ltp;
          upd_dt    <= sel_dt;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < N_SYN; i++) begin
        if (ltp_set[i]) begin
          ltp_pend[i] <= 1'b1;
          ltp_dt[i]   <= ltp_new_dt[i];
        end
        if (ltd_set[i]) begin
          ltd_pend[i] <= 1'b1;
          ltd_dt[i]   <= post_timer;
        end
      end
    end
  end

`ifndef STDP_SCHED_RR_EN
  logic unused_last;
  assign unused_last = ^I_LAST;
`endif

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Directed bench for stdp_update_scheduler.
// Expected arbitration order follows STDP_SCHED_RR_EN when it is defined.
module tb_stdp_update_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] pre_spike;
  logic       post_spike;
  logic [1:0] wt_rd_idx;
  logic [7:0] wt_rd_data;
  logic       busy;
  logic       upd_valid;
  logic [1:0] upd_idx;
  logic       upd_ltp;
  logic [7:0] upd_dt;

  int cmp = 0;
  int mis = 0;
  int upd_cnt = 0;
  int cnt0;
  logic [1:0] ord [4];

  stdp_update_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .wt_rd_idx  (wt_rd_idx),
    .wt_rd_data (wt_rd_data),
    .busy       (busy),
    .upd_valid  (upd_valid),
    .upd_idx    (upd_idx),
    .upd_ltp    (upd_ltp),
    .upd_dt     (upd_dt)
  );

  always #5 clk = ~clk;

  // Count every weight write seen
  always @(negedge clk) if (upd_valid === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    step(1);
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] idx,
                    input logic [7:0] exp);
    wt_rd_idx = idx;
    #1;
    check(tag, {24'd0, wt_rd_data}, {24'd0, exp});
  endtask

  task automatic expect_upd(input string tag, input logic [1:0] idx,
                            input logic ltp, input logic [7:0] dt);
    check({tag, "_valid"}, {31'd0, upd_valid}, 32'd1);
    check({tag, "_idx"}, {30'd0, upd_idx}, {30'd0, idx});
    check({tag, "_ltp"}, {31'd0, upd_ltp}, {31'd0, ltp});
    check({tag, "_dt"}, {24'd0, upd_dt}, {24'd0, dt});
  endtask

  initial begin
`ifdef STDP_SCHED_RR_EN
    ord[0] = 2'd3; ord[1] = 2'd0; ord[2] = 2'd1; ord[3] = 2'd2;
`else
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd3;
`endif
    rst_n = 1'b0;
    en = 1'b1;
    pre_spike = '0;
    post_spike = 1'b0;
    wt_rd_idx = '0;
    step(3);
    rst_n = 1'b1;

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, upd_valid}, 32'd0);
    check("rst_uidx", {30'd0, upd_idx}, 32'd0);
    check("rst_udt", {24'd0, upd_dt}, 32'd0);
    for (int i = 0; i < 4; i++) rd("rst_w", 2'(i), 8'd16);

    // LTP dt=5 on synapse 1
    pulse(4'b0010, 1'b0);
    step(5);
    pulse(4'b0000, 1'b1);
    check("ltp_busy", {31'd0, busy}, 32'd1);
    step(1);
    check("ltp_lat", {31'd0, upd_valid}, 32'd0);
    step(1);
    expect_upd("ltp", 2'd1, 1'b1, 8'd5);
    rd("ltp_w1", 2'd1, 8'd27);

    // LTD dt=3 on synapse 2, then again to saturate at 0
    step(20);
    pulse(4'b0000, 1'b1);
    step(3);
    pulse(4'b0100, 1'b0);
    step(2);
    expect_upd("ltd1", 2'd2, 1'b0, 8'd3);
    rd("ltd1_w2", 2'd2, 8'd3);
    step(20);
    pulse(4'b0000, 1'b1);
    step(3);
    pulse(4'b0100, 1'b0);
    step(2);
    expect_upd("ltd2", 2'd2, 1'b0, 8'd3);
    rd("ltd2_w2", 2'd2, 8'd0);
    check("ltd2_busy", {31'd0, busy}, 32'd0);

    // burst of four LTP requests, dt=0
    step(20);
    pulse(4'b1111, 1'b0);
    pulse(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("arb1_gap", {31'd0, upd_valid}, 32'd0);
      step(1);
      expect_upd("arb1", 2'(k), 1'b1, 8'd0);
    end
    check("arb1_busy", {31'd0, busy}, 32'd0);
    rd("arb1_w0", 2'd0, 8'd32);
    rd("arb1_w1", 2'd1, 8'd43);
    rd("arb1_w2", 2'd2, 8'd16);
    rd("arb1_w3", 2'd3, 8'd32);

    // single grant on 2 moves a round-robin pointer to 3
    step(20);
    pulse(4'b0100, 1'b0);
    pulse(4'b0000, 1'b1);
    step(2);
    expect_upd("arb2", 2'd2, 1'b1, 8'd0);
    rd("arb2_w2", 2'd2, 8'd32);

    // second full burst
    step(20);
    pulse(4'b1111, 1'b0);
    pulse(4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(2);
      expect_upd("arb3", ord[k], 1'b1, 8'd0);
    end
    rd("arb3_w0", 2'd0, 8'd48);
    rd("arb3_w1", 2'd1, 8'd59);
    rd("arb3_w2", 2'd2, 8'd48);
    rd("arb3_w3", 2'd3, 8'd48);

    // coincident pre[0]+post while post timer is in window: LTP only
    step(20);
    pulse(4'b0000, 1'b1);
    step(3);
    cnt0 = upd_cnt;
    pulse(4'b0001, 1'b1);
    step(2);
    expect_upd("sim", 2'd0, 1'b1, 8'd0);
    check("sim_busy", {31'd0, busy}, 32'd0);
    rd("sim_w0", 2'd0, 8'd64);
    step(4);
    check("sim_cnt", upd_cnt - cnt0, 32'd1);

    // window edge: dt=15 updates by 1
    step(20);
    pulse(4'b1000, 1'b0);
    step(15);
    pulse(4'b0000, 1'b1);
    step(2);
    expect_upd("win15", 2'd3, 1'b1, 8'd15);
    rd("win15_w3", 2'd3, 8'd49);

    // dt=16 is outside the window
    step(20);
    cnt0 = upd_cnt;
    pulse(4'b1000, 1'b0);
    step(16);
    pulse(4'b0000, 1'b1);
    check("win16_busy", {31'd0, busy}, 32'd0);
    step(4);
    check("win16_cnt", upd_cnt - cnt0, 32'd0);
    rd("win16_w3", 2'd3, 8'd49);

    // en=0 blocks captures
    step(20);
    cnt0 = upd_cnt;
    en = 1'b0;
    pulse(4'b0010, 1'b0);
    pulse(4'b0000, 1'b1);
    check("en0_busy", {31'd0, busy}, 32'd0);
    step(4);
    check("en0_cnt", upd_cnt - cnt0, 32'd0);
    rd("en0_w1", 2'd1, 8'd59);

    // queued request drains after en drops
    step(20);
    en = 1'b1;
    pulse(4'b0100, 1'b0);
    pulse(4'b0000, 1'b1);
    en = 1'b0;
    step(2);
    expect_upd("drain", 2'd2, 1'b1, 8'd0);
    rd("drain_w2", 2'd2, 8'd64);
    en = 1'b1;

    // reset during APPLY aborts the write
    step(20);
    pulse(4'b0001, 1'b0);
    pulse(4'b0000, 1'b1);
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mid_valid", {31'd0, upd_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    rd("mid_w0", 2'd0, 8'd16);
    rd("mid_w2", 2'd2, 8'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
